// File: rtl/np_tanh_div_if.sv
// Handshake bundle for np_tanh_div: operand channel (x_in/y_in) in,
// result channel (q_out plus flags) out, each with valid/ready.
interface np_tanh_div_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] x_in;
  logic [DATA_WIDTH-1:0] y_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] q_out;
  logic                  out_sat;
  logic                  out_err;

  // Producer of operands and consumer of results (CORDIC side + activation buffer).
  modport master (
    output in_valid, x_in, y_in, out_ready,
    input  in_ready, out_valid, q_out, out_sat, out_err
  );

  // The divider itself.
  modport slave (
    input  in_valid, x_in, y_in, out_ready,
    output in_ready, out_valid, q_out, out_sat, out_err
  );
endinterface

// File: rtl/np_tanh_div.sv
// np_tanh_div: post-CORDIC tanh = sinh/cosh using an iterative restoring
// divider, one quotient bit per cycle (weights 2^FRAC_BITS down to 2^0).
// Magnitude is clamped to 2^FRAC_BITS-1 and the sign of y reapplied.
// Optional build macro NP_TANH_DIV_ROUND_EN adds a guard-bit iteration and
// rounds the magnitude half away from zero before the clamp.
module np_tanh_div #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  np_tanh_div_if.slave   bus
);

`ifdef NP_TANH_DIV_ROUND_EN
  localparam int ITER = FRAC_BITS + 2;
`else
  localparam int ITER = FRAC_BITS + 1;
`endif
  localparam int QW = ITER;                 // quotient bits produced
  localparam int CW = $clog2(ITER + 1);     // iteration counter width
  localparam int MW = FRAC_BITS + 2;        // pre-clamp magnitude width

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t                r_state;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic                  r_out_sat;
  logic                  r_out_err;
  logic [DATA_WIDTH-1:0] r_q_out;
  logic [DATA_WIDTH-1:0] r_div;      // divisor x (known positive)
  logic [DATA_WIDTH-1:0] r_rem;      // partial remainder
  logic [QW-2:0]         r_quo;      // quotient bits collected so far
  logic [CW-1:0]         r_cnt;
  logic                  r_sign;
  logic                  r_y0;       // LSB of |y|, fed in on the first iteration
  logic                  r_pre_sat;

  logic                  w_x_bad;
  logic [DATA_WIDTH-1:0] w_y_mag;
  logic                  w_pre_sat;
  logic                  w_feed;
  logic [DATA_WIDTH:0]   w_trial;
  logic                  w_ge;
  logic [DATA_WIDTH-1:0] w_rem_next;
  logic [QW-1:0]         w_quo_next;
  logic [MW-1:0]         w_m_raw;
  logic                  w_sat;
  logic [FRAC_BITS-1:0]  w_m;
  logic [DATA_WIDTH-1:0] w_mag_ext;
  logic [DATA_WIDTH-1:0] w_q_final;
  logic                  w_last;

  // Operand capture: |y| fits DATA_WIDTH unsigned bits even for the most
  // negative y (2^(DATA_WIDTH-1)); 2*x needs one extra bit.
  assign w_x_bad   = bus.x_in[DATA_WIDTH-1] | (bus.x_in == '0);
  assign w_y_mag   = bus.y_in[DATA_WIDTH-1] ? -bus.y_in : bus.y_in;
  assign w_pre_sat = {1'b0, w_y_mag} >= {bus.x_in, 1'b0};

  // Long division of |y|*2^FRAC_BITS by x, keeping only the low ITER quotient
  // bits. The remainder starts at |y|>>1 (valid whenever |y| < 2x); the next
  // dividend bit is |y|[0] on the first step and zero afterwards.
  assign w_feed     = (r_cnt == '0) ? r_y0 : 1'b0;
  assign w_trial    = {r_rem, w_feed};
  assign w_ge       = w_trial >= {1'b0, r_div};
  assign w_rem_next = w_ge ? DATA_WIDTH'(w_trial - {1'b0, r_div}) : w_trial[DATA_WIDTH-1:0];
  assign w_quo_next = {r_quo, w_ge};
  assign w_last     = (r_cnt == CW'(ITER - 1));

`ifdef NP_TANH_DIV_ROUND_EN
  // Quotient carries one guard bit below 2^0; adding it rounds half up.
  assign w_m_raw = {1'b0, w_quo_next[QW-1:1]} + MW'(w_quo_next[0]);
`else
  assign w_m_raw = {1'b0, w_quo_next};
`endif

  // Clamp after any rounding, then reapply the sign (truncation toward zero).
  assign w_sat     = r_pre_sat | (w_m_raw[MW-1:FRAC_BITS] != '0);
  assign w_m       = w_sat ? {FRAC_BITS{1'b1}} : w_m_raw[FRAC_BITS-1:0];
  assign w_mag_ext = {{(DATA_WIDTH - FRAC_BITS){1'b0}}, w_m};
  assign w_q_final = r_sign ? -w_mag_ext : w_mag_ext;

  // Control FSM and datapath registers; all outputs come straight from flops.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: only control and output registers are reset; the divider
      // datapath is always reloaded at acceptance before it is used.
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_sat   <= 1'b0;
      r_out_err   <= 1'b0;
      r_q_out     <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_in_ready <= 1'b0;
            if (w_x_bad) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_q_out     <= '0;
              r_out_err   <= 1'b1;
              r_out_sat   <= 1'b0;
            end else begin
              r_state   <= S_BUSY;
              r_sign    <= bus.y_in[DATA_WIDTH-1];
              r_y0      <= w_y_mag[0];
              r_rem     <= w_y_mag >> 1;
              r_div     <= bus.x_in;
              r_pre_sat <= w_pre_sat;
              r_quo     <= '0;
              r_cnt     <= '0;
            end
          end
        end
        S_BUSY: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next[QW-2:0];
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_q_out     <= w_q_final;
            r_out_sat   <= w_sat;
            r_out_err   <= 1'b0;
            r_cnt       <= '0;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_sat   <= 1'b0;
            r_out_err   <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.q_out     = r_q_out;
  assign bus.out_sat   = r_out_sat;
  assign bus.out_err   = r_out_err;

endmodule

// File: tb/tb_np_tanh_div.sv
// Scoreboard bench for np_tanh_div: a driver pushes model results at each
// accepted operand pair, a monitor pops and compares whenever a result shows.
module tb_np_tanh_div;
  localparam int DW = 32;
  localparam int FW = 16;
`ifdef NP_TANH_DIV_ROUND_EN
  localparam int ITER = FW + 2;
`else
  localparam int ITER = FW + 1;
`endif

  typedef struct {
    logic [DW-1:0] q;
    logic          sat;
    logic          err;
    int            lat;   // edges from the accept edge to out_valid rising
    int            acc;   // edge count at acceptance
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_vec;
  int   n_err;
  int   ready_mode;       // 0 random, 1 held low, 2 held high
  exp_t sb[$];

  np_tanh_div_if #(.DATA_WIDTH(DW)) bus ();

  np_tanh_div #(.DATA_WIDTH(DW), .FRAC_BITS(FW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // Reference: plain integer arithmetic on the real-valued ratio.
  function automatic exp_t model(input logic [DW-1:0] x, input logic [DW-1:0] y);
    exp_t   e;
    longint xs, ys, mag, num, m, lim;
    xs = longint'($signed(x));
    ys = longint'($signed(y));
    e.acc = 0;
    if (xs <= 0) begin
      e.q = '0; e.sat = 1'b0; e.err = 1'b1; e.lat = 0;
      return e;
    end
    mag = (ys < 0) ? -ys : ys;
    num = mag * (longint'(1) << FW);
    m   = num / xs;
`ifdef NP_TANH_DIV_ROUND_EN
    if ((num % xs) * 2 >= xs) m = m + 1;
`endif
    lim   = (longint'(1) << FW) - 1;
    e.sat = (m > lim);
    if (m > lim) m = lim;
    e.q   = DW'((ys < 0) ? -m : m);
    e.err = 1'b0;
    e.lat = ITER;
    return e;
  endfunction

  // Consumer backpressure.
  always @(negedge clk) begin
    if (ready_mode == 0) bus.out_ready = ($urandom_range(0, 3) != 0);
    else                 bus.out_ready = (ready_mode == 2);
  end

  // Monitor: compare each new result, then check it stays put until taken.
  initial begin : monitor
    exp_t cur;
    bit   prev;
    bit   hs;
    prev = 1'b0;
    hs   = 1'b0;
    cur  = '{q: '0, sat: 1'b0, err: 1'b0, lat: 0, acc: 0};
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        prev = 1'b0;
        hs   = 1'b0;
      end else begin
        if (hs) begin
          check("ready_after_take", bus.in_ready, 1'b1);
          check("valid_drop_after_take", bus.out_valid, 1'b0);
        end
        hs = 1'b0;
        if (bus.out_valid) begin
          if (!prev) begin
            if (sb.size() == 0) begin
              n_vec++;
              n_err++;
              $display("FAIL unexpected_result: got q=%0h with nothing outstanding", bus.q_out);
            end else begin
              cur = sb.pop_front();
              check("q_out", bus.q_out, cur.q);
              check("out_sat", bus.out_sat, cur.sat);
              check("out_err", bus.out_err, cur.err);
              check("latency", cyc - cur.acc, cur.lat);
            end
          end else begin
            check("q_hold", bus.q_out, cur.q);
            check("sat_hold", bus.out_sat, cur.sat);
            check("err_hold", bus.out_err, cur.err);
          end
          check("in_ready_in_done", bus.in_ready, 1'b0);
          if (bus.out_ready) hs = 1'b1;
        end
        prev = bus.out_valid & ~bus.out_ready;
      end
    end
  end

  // Present one operand pair, hold it until accepted, log the expectation.
  task automatic send(input logic [DW-1:0] x, input logic [DW-1:0] y);
    exp_t e;
    int   t;
    t = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.x_in     = x;
    bus.y_in     = y;
    while (!bus.in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      bound_fail("accept_timeout");
      bus.in_valid = 1'b0;
    end else begin
      e     = model(x, y);
      e.acc = cyc + 1;
      sb.push_back(e);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.x_in     = $urandom();
      bus.y_in     = $urandom();
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || bus.out_valid) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) bound_fail("drain_timeout");
    @(negedge clk);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [DW-1:0] x, y;
    logic [DW-1:0] dx[10];
    logic [DW-1:0] dy[10];
    int t;
    longint lim;

    n_vec = 0; n_err = 0; cyc = 0; ready_mode = 2;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.x_in = '0; bus.y_in = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_q_out", bus.q_out, '0);
    check("rst_out_sat", bus.out_sat, 1'b0);
    check("rst_out_err", bus.out_err, 1'b0);

    // Directed cases, consumer always ready.
    dx = '{32'h0002_0000, 32'h0002_0000, 32'h0003_0000, 32'h0001_0000, 32'h0001_0000,
           32'h0000_0000, 32'h0002_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'h0010_0000};
    dy = '{32'h0001_0000, 32'hFFFF_0000, 32'h0002_0000, 32'h0001_0000, 32'h7FFF_FFFF,
           32'h0001_0000, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
    foreach (dx[i]) begin
      send(dx[i], dy[i]);
      drain();
    end
    send(32'h8000_0000, 32'h0001_0000);
    drain();

    // Error result stalled for 5 cycles, then released.
    ready_mode = 1;
    bus.out_ready = 1'b0;
    send(32'h0000_0000, 32'h0001_0000);
    t = 0;
    while (!bus.out_valid && t < 10) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!bus.out_valid) bound_fail("err_valid_wait");
    repeat (5) @(negedge clk);
    ready_mode = 2;
    bus.out_ready = 1'b1;
    drain();

    // Reset in the middle of BUSY discards the operation.
    send(32'h0002_0000, 32'h0001_0000);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_in_ready", bus.in_ready, 1'b1);
    check("abort_out_valid", bus.out_valid, 1'b0);
    repeat (ITER + 3) @(negedge clk);
    check("abort_no_result", bus.out_valid, 1'b0);
    send(32'h0002_0000, 32'h0001_0000);
    drain();

    // Randomised traffic with random backpressure and back-to-back offers.
    ready_mode = 0;
    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 9))
        0:       x = ($urandom_range(0, 1) != 0) ? '0 : {1'b1, 31'($urandom())};
        1:       x = 32'($urandom_range(1, 8));
        default: x = (32'($urandom()) & 32'h7FFF_FFFF) >> $urandom_range(0, 30);
      endcase
      if (x == '0 && $urandom_range(0, 1) != 0) x = 32'h0001_0000;
      lim = 2 * longint'($signed(x));
      if (lim <= 0) lim = 64'h1_0000_0000;
      case ($urandom_range(0, 7))
        0:       y = 32'h8000_0000;
        1:       y = '0;
        2:       y = 32'h7FFF_FFFF;
        3:       y = $urandom();
        default: y = 32'(longint'($urandom()) % lim);
      endcase
      if ($urandom_range(0, 1) != 0 && y != 32'h8000_0000) y = -y;
      send(x, y);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
